// File: rtl/gpio_bank_pkg.sv
// -----------------------------------------------------------------------------
// gpio_bank_pkg
// Shared definitions for the GPIO bank:
//   - bus and register-select widths
//   - register offsets GPIO_DATA .. GPIO_PEND
//   - a helper that identifies the offsets whose read returns OUT
// No ports (package).
// -----------------------------------------------------------------------------
package gpio_bank_pkg;

  localparam int BUS_W  = 16;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] GPIO_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] GPIO_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] GPIO_SET     = 3'd2;
  localparam logic [ADDR_W-1:0] GPIO_CLR     = 3'd3;
  localparam logic [ADDR_W-1:0] GPIO_TGL     = 3'd4;
  localparam logic [ADDR_W-1:0] GPIO_RISE_EN = 3'd5;
  localparam logic [ADDR_W-1:0] GPIO_FALL_EN = 3'd6;
  localparam logic [ADDR_W-1:0] GPIO_PEND    = 3'd7;

  // SET, CLR and TGL are write-only actions on OUT; reading them shows OUT.
  function automatic logic addr_reads_out(input logic [ADDR_W-1:0] a);
    logic r;
    case (a)
      GPIO_SET, GPIO_CLR, GPIO_TGL: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// -----------------------------------------------------------------------------
// gpio_bank_if
// Register-access bus between the J1a I/O strobes and the GPIO bank.
//   cs     bank selected
//   wr     write strobe (qualified by cs)
//   rd     read strobe (qualified by cs)
//   addr   register select
//   wdata  write data
//   rdata  registered read data (driven by the bank)
// Modports: master (CPU side) and slave (GPIO bank side).
// -----------------------------------------------------------------------------
interface gpio_bank_if;
  import gpio_bank_pkg::*;

  logic              cs;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  logic [BUS_W-1:0]  rdata;

  modport master (output cs, output wr, output rd, output addr, output wdata,
                  input rdata);
  modport slave  (input cs, input wr, input rd, input addr, input wdata,
                  output rdata);
endinterface

// File: rtl/gpio_bank_sync_edge.sv
// -----------------------------------------------------------------------------
// gpio_sync_edge
// Per-bank input synchroniser with edge detection.
//   clk        system clock
//   reset      asynchronous active-high reset
//   pin_i      raw asynchronous pad inputs
//   rise_en_i  per-pin rising-edge enable
//   fall_en_i  per-pin falling-edge enable
//   sync_o     synchronised inputs (last synchroniser stage)
//   rise_o     enabled rising edges seen on sync_o this cycle
//   fall_o     enabled falling edges seen on sync_o this cycle
// -----------------------------------------------------------------------------
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Synchroniser chain and previous-sample register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      stage_q[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  // Enables are applied at detection time, so enabling a pin never
  // reports a transition that happened while it was disabled.
  assign rise_o = sync_o & ~prev_q & rise_en_i;
  assign fall_o = ~sync_o & prev_q & fall_en_i;

endmodule

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
// Parametrised GPIO bank: register file, read mux, edge-pending flags and irq.
//   clk      system clock
//   reset    asynchronous active-high reset
//   bus      register-access bus (gpio_bank_if.slave)
//   pin_in   raw pad inputs
//   pin_out  output data to pads (OUT register)
//   pin_oe   output enable to pads, 1 = drive (DIR register)
//   irq      registered OR of all pending edge flags
// Registers are WIDTH bits; bus bits above WIDTH read as 0 and are ignored
// on write.
// -----------------------------------------------------------------------------
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  gpio_bank_if.slave       bus,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q,     out_d;
  logic [WIDTH-1:0] dir_q,     dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q,    pend_d;
  logic [BUS_W-1:0] rdata_q,   rdata_d;
  logic             irq_q,     irq_d;

  logic             wr_en_s;
  logic             rd_en_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] rsel_s;
  logic [BUS_W-1:0] rsel_ext_s;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;

  assign wr_en_s = bus.cs & bus.wr;
  assign rd_en_s = bus.cs & bus.rd;
  assign wdata_s = bus.wdata[WIDTH-1:0];

  generate
    if (WIDTH < BUS_W) begin : g_unused_wdata
      logic unused_wdata_s;
      assign unused_wdata_s = ^bus.wdata[BUS_W-1:WIDTH];
    end
  endgenerate

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .pin_i     (pin_in),
    .rise_en_i (rise_en_q),
    .fall_en_i (fall_en_q),
    .sync_o    (sync_s),
    .rise_o    (rise_s),
    .fall_o    (fall_s)
  );

  // Register write decode and PEND next state.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_s     = '0;
    if (wr_en_s) begin
      case (bus.addr)
        GPIO_DATA:    out_d     = wdata_s;
        GPIO_DIR:     dir_d     = wdata_s;
        GPIO_SET:     out_d     = out_q | wdata_s;
        GPIO_CLR:     out_d     = out_q & ~wdata_s;
        GPIO_TGL:     out_d     = out_q ^ wdata_s;
        GPIO_RISE_EN: rise_en_d = wdata_s;
        GPIO_FALL_EN: fall_en_d = wdata_s;
        GPIO_PEND:    w1c_s     = wdata_s;
        default:      out_d     = out_q;
      endcase
    end else begin
      w1c_s = '0;
    end
    // New edges are ORed in after the clear so a coincident edge wins.
    pend_d = (pend_q & ~w1c_s) | rise_s | fall_s;
    irq_d  = |pend_q;
  end

  // Read mux: samples current (pre-write) register contents.
  always_comb begin
    rsel_s = '0;
    if (addr_reads_out(bus.addr)) begin
      rsel_s = out_q;
    end else begin
      case (bus.addr)
        GPIO_DATA:    rsel_s = sync_s;
        GPIO_DIR:     rsel_s = dir_q;
        GPIO_RISE_EN: rsel_s = rise_en_q;
        GPIO_FALL_EN: rsel_s = fall_en_q;
        GPIO_PEND:    rsel_s = pend_q;
        default:      rsel_s = out_q;
      endcase
    end
    rsel_ext_s              = '0;
    rsel_ext_s[WIDTH-1:0]   = rsel_s;
    if (rd_en_s) begin
      rdata_d = rsel_ext_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= OUT_RESET;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign pin_out   = out_q;
  assign pin_oe    = dir_q;
  assign irq       = irq_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_gpio_bank.sv
// -----------------------------------------------------------------------------
// tb_gpio_bank
// Directed bench for gpio_bank (WIDTH=8, SYNC_STAGES=2, OUT_RESET=8'hA5).
// Read expectations go into a queue when the read is issued; a monitor
// compares rdata on the falling edge of the cycle after each read strobe.
// Pin and irq levels are compared directly at fixed points.
// -----------------------------------------------------------------------------
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pin_in;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;
  logic       irq;

  gpio_bank_if bus ();

  gpio_bank #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .OUT_RESET   (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q [$];
  string       name_q [$];
  logic        rd_seen = 1'b0;
  logic [15:0] mon_exp;
  string       mon_name;

  task automatic check16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  // Remember whether the previous cycle carried a read strobe.
  always @(posedge clk) rd_seen <= bus.cs & bus.rd;

  // Scoreboard monitor: rdata is valid the cycle after the strobe.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_read: got 0x%04h with no expected value", bus.rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check16(mon_name, bus.rdata, mon_exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    cyc();
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp,
                          input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    cyc();
    bus.cs = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    cyc();
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.cs    = 1'b0;
    bus.wr    = 1'b0;
    bus.rd    = 1'b0;
    bus.addr  = 3'd0;
    bus.wdata = 16'h0000;
    pin_in    = 8'h30;
    repeat (3) @(posedge clk);
    #1;
    check16("rst_pin_oe",  {8'h00, pin_oe}, 16'h0000);
    check16("rst_pin_out", {8'h00, pin_out}, 16'h00A5);
    check16("rst_irq",     {15'h0000, irq}, 16'h0000);
    check16("rst_rdata",   bus.rdata, 16'h0000);
    reset = 1'b0;
    idle(3);

    // Reset values of every register.
    bus_read(GPIO_DATA,    16'h0030, "rd_data_rst");
    bus_read(GPIO_DIR,     16'h0000, "rd_dir_rst");
    bus_read(GPIO_SET,     16'h00A5, "rd_set_rst");
    bus_read(GPIO_CLR,     16'h00A5, "rd_clr_rst");
    bus_read(GPIO_TGL,     16'h00A5, "rd_tgl_rst");
    bus_read(GPIO_RISE_EN, 16'h0000, "rd_rise_rst");
    bus_read(GPIO_FALL_EN, 16'h0000, "rd_fall_rst");
    bus_read(GPIO_PEND,    16'h0000, "rd_pend_rst");

    // Output register and atomic operations.
    bus_write(GPIO_DIR, 16'h00FF);
    check16("oe_after_dir", {8'h00, pin_oe}, 16'h00FF);
    bus_write(GPIO_DATA, 16'h0012);
    check16("out_data12", {8'h00, pin_out}, 16'h0012);
    bus_write(GPIO_SET, 16'h0080);
    check16("out_set80", {8'h00, pin_out}, 16'h0092);
    bus_write(GPIO_CLR, 16'h0002);
    check16("out_clr02", {8'h00, pin_out}, 16'h0090);
    bus_write(GPIO_TGL, 16'h0011);
    check16("out_tgl11", {8'h00, pin_out}, 16'h0081);
    bus_write(GPIO_DATA, 16'hFFFF);
    check16("out_dataFFFF", {8'h00, pin_out}, 16'h00FF);
    bus_read(GPIO_SET, 16'h00FF, "rd_out_upper_zero");
    bus_read(GPIO_DIR, 16'h00FF, "rd_dir_ff");
    // Read and write together: read returns the pre-write OUT.
    bus_rw(GPIO_TGL, 16'h000F, 16'h00FF, "rw_pre_write");
    check16("out_after_rw", {8'h00, pin_out}, 16'h00F0);

    // Rising edge on pin 0: PEND set on the third edge after the pad change.
    bus_write(GPIO_RISE_EN, 16'h0001);
    pin_in[0] = 1'b1;
    bus_read(GPIO_PEND, 16'h0000, "rise_pend_e1");
    bus_read(GPIO_PEND, 16'h0000, "rise_pend_e2");
    bus_read(GPIO_PEND, 16'h0000, "rise_pend_e3");
    check16("rise_irq_e3", {15'h0000, irq}, 16'h0000);
    bus_read(GPIO_PEND, 16'h0001, "rise_pend_e4");
    check16("rise_irq_e4", {15'h0000, irq}, 16'h0001);
    bus_write(GPIO_PEND, 16'h0001);
    check16("clr_irq_lag", {15'h0000, irq}, 16'h0001);
    cyc();
    check16("clr_irq_low", {15'h0000, irq}, 16'h0000);
    pin_in[0] = 1'b0;
    idle(5);
    bus_read(GPIO_PEND, 16'h0000, "no_capture_on_fall");
    check16("no_irq_on_fall", {15'h0000, irq}, 16'h0000);

    // Falling edges on pin 2 and clear-versus-new-edge priority.
    bus_write(GPIO_FALL_EN, 16'h0004);
    pin_in[2] = 1'b1;
    idle(4);
    pin_in[2] = 1'b0;
    idle(4);
    check16("fall_irq", {15'h0000, irq}, 16'h0001);
    bus_read(GPIO_PEND, 16'h0004, "fall_pend");
    pin_in[2] = 1'b1;
    idle(4);
    pin_in[2] = 1'b0;
    idle(2);
    bus_write(GPIO_PEND, 16'h0004);
    bus_read(GPIO_PEND, 16'h0004, "set_wins_over_clear");
    check16("set_wins_irq", {15'h0000, irq}, 16'h0001);
    bus_write(GPIO_PEND, 16'h0004);
    check16("clr2_irq_lag", {15'h0000, irq}, 16'h0001);
    cyc();
    check16("clr2_irq_low", {15'h0000, irq}, 16'h0000);
    bus_read(GPIO_PEND, 16'h0000, "clr2_pend");

    // Enabling after the pin is already high captures nothing.
    bus_write(GPIO_RISE_EN, 16'h0000);
    pin_in[0] = 1'b1;
    idle(6);
    bus_write(GPIO_RISE_EN, 16'h0001);
    idle(3);
    bus_read(GPIO_PEND, 16'h0000, "late_enable_no_pend");
    check16("late_enable_no_irq", {15'h0000, irq}, 16'h0000);
    pin_in[0] = 1'b0;
    idle(4);
    pin_in[0] = 1'b1;
    idle(4);
    bus_read(GPIO_PEND, 16'h0001, "late_enable_new_edge");
    cyc();
    check16("late_enable_irq", {15'h0000, irq}, 16'h0001);

    // Asynchronous reset mid-cycle.
    bus_read(GPIO_DIR, 16'h00FF, "dir_before_reset");
    cyc();
    check16("oe_before_reset", {8'h00, pin_oe}, 16'h00FF);
    #2;
    reset = 1'b1;
    #1;
    check16("async_pin_oe",  {8'h00, pin_oe}, 16'h0000);
    check16("async_irq",     {15'h0000, irq}, 16'h0000);
    check16("async_rdata",   bus.rdata, 16'h0000);
    check16("async_pin_out", {8'h00, pin_out}, 16'h00A5);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    bus_read(GPIO_DATA,    16'h0031, "post_rst_data");
    bus_read(GPIO_DIR,     16'h0000, "post_rst_dir");
    bus_read(GPIO_TGL,     16'h00A5, "post_rst_out");
    bus_read(GPIO_RISE_EN, 16'h0000, "post_rst_rise");
    bus_read(GPIO_FALL_EN, 16'h0000, "post_rst_fall");
    bus_read(GPIO_PEND,    16'h0000, "post_rst_pend");
    check16("post_rst_irq", {15'h0000, irq}, 16'h0000);
    idle(2);
    check16("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
